// File: rtl/vga_fb_pixel_stream_if.sv
// Framebuffer read port between the pixel stream stage and the framebuffer memory.
// The master issues read strobes and addresses. The slave returns data a fixed number of cycles later.
interface vga_fb_pixel_stream_if #(
  parameter int ADDR_BITS  = 19,
  parameter int PIXEL_BITS = 12
);
  logic                  fb_rd_en;
  logic [ADDR_BITS-1:0]  fb_addr;
  logic [PIXEL_BITS-1:0] fb_data;

  modport master (
    output fb_rd_en,
    output fb_addr,
    input  fb_data
  );

  modport slave (
    input  fb_rd_en,
    input  fb_addr,
    output fb_data
  );
endinterface

// File: rtl/vga_fb_pixel_stream.sv
// Turns the column/row stream into framebuffer reads and a display pixel stream.
// Sync and visible flags are delayed so that they come out aligned with the returned pixel data.
module vga_fb_pixel_stream #(
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_WHOLE_LINE   = 800,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_WHOLE_FRAME  = 525,
  parameter int READ_LATENCY   = 2,
  parameter int PIXEL_BITS     = 12,
  parameter int ADDR_BITS      = 19,
  localparam int COLUMN_BITS   = $clog2(H_WHOLE_LINE),
  localparam int ROW_BITS      = $clog2(V_WHOLE_FRAME)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [COLUMN_BITS-1:0] column,
  input  logic [ROW_BITS-1:0]    row,
  vga_fb_pixel_stream_if.master  fb,
  output logic                   pix_valid,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   visible,
  output logic [PIXEL_BITS-1:0]  rgb
);

  localparam logic [COLUMN_BITS-1:0] H_VIS_C      = COLUMN_BITS'(H_VISIBLE);
  localparam logic [COLUMN_BITS-1:0] H_SYNC_BEG_C = COLUMN_BITS'(H_VISIBLE + H_FRONT_PORCH);
  localparam logic [COLUMN_BITS-1:0] H_SYNC_END_C = COLUMN_BITS'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [ROW_BITS-1:0]    V_VIS_C      = ROW_BITS'(V_VISIBLE);
  localparam logic [ROW_BITS-1:0]    V_SYNC_BEG_C = ROW_BITS'(V_VISIBLE + V_FRONT_PORCH);
  localparam logic [ROW_BITS-1:0]    V_SYNC_END_C = ROW_BITS'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

  typedef struct packed {
    logic valid;
    logic vis;
    logic hs_n;
    logic vs_n;
  } meta_t;

  localparam meta_t META_IDLE = '{valid: 1'b0, vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  logic                  vis_s;
  logic                  hs_n_s;
  logic                  vs_n_s;
  logic                  frame_start_s;

  logic                  fb_rd_en_d, fb_rd_en_q;
  logic [ADDR_BITS-1:0]  fb_addr_d, fb_addr_q;
  logic [ADDR_BITS-1:0]  addr_cnt_d, addr_cnt_q;
  meta_t                 meta_d [0:READ_LATENCY];
  meta_t                 meta_q [0:READ_LATENCY];
  logic                  pix_valid_d, pix_valid_q;
  logic                  hsync_d, hsync_q;
  logic                  vsync_d, vsync_q;
  logic                  visible_d, visible_q;
  logic [PIXEL_BITS-1:0] rgb_d, rgb_q;

  // Region decode of the incoming coordinate.
  always_comb begin
    vis_s         = (column < H_VIS_C) && (row < V_VIS_C);
    hs_n_s        = !((column >= H_SYNC_BEG_C) && (column < H_SYNC_END_C));
    vs_n_s        = !((row >= V_SYNC_BEG_C) && (row < V_SYNC_END_C));
    frame_start_s = (column == {COLUMN_BITS{1'b0}}) && (row == {ROW_BITS{1'b0}});
  end

  // Next-state logic for the read issue stage, delay line and output register.
  always_comb begin
    fb_rd_en_d  = 1'b0;
    fb_addr_d   = fb_addr_q;
    addr_cnt_d  = addr_cnt_q;
    meta_d[0]   = META_IDLE;
    for (int i = 1; i <= READ_LATENCY; i++) begin
      meta_d[i] = meta_q[i-1];
    end
    pix_valid_d = 1'b0;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    visible_d   = visible_q;
    rgb_d       = rgb_q;

    if (enable) begin
      meta_d[0]  = '{valid: 1'b1, vis: vis_s, hs_n: hs_n_s, vs_n: vs_n_s};
      fb_rd_en_d = vis_s;
      // The linear counter replaces row*H_VISIBLE+column; frame start re-anchors it.
      if (frame_start_s) begin
        fb_addr_d  = {ADDR_BITS{1'b0}};
        addr_cnt_d = ADDR_BITS'(1);
      end else if (vis_s) begin
        fb_addr_d  = addr_cnt_q;
        addr_cnt_d = addr_cnt_q + ADDR_BITS'(1);
      end else begin
        fb_addr_d  = fb_addr_q;
        addr_cnt_d = addr_cnt_q;
      end
    end else begin
      meta_d[0]  = META_IDLE;
      fb_rd_en_d = 1'b0;
    end

    if (meta_q[READ_LATENCY].valid) begin
      pix_valid_d = 1'b1;
      hsync_d     = meta_q[READ_LATENCY].hs_n;
      vsync_d     = meta_q[READ_LATENCY].vs_n;
      visible_d   = meta_q[READ_LATENCY].vis;
      rgb_d       = meta_q[READ_LATENCY].vis ? fb.fb_data : {PIXEL_BITS{1'b0}};
    end else begin
      pix_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_rd_en_q  <= 1'b0;
      fb_addr_q   <= {ADDR_BITS{1'b0}};
      addr_cnt_q  <= {ADDR_BITS{1'b0}};
      for (int i = 0; i <= READ_LATENCY; i++) begin
        meta_q[i] <= META_IDLE;
      end
      pix_valid_q <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      visible_q   <= 1'b0;
      rgb_q       <= {PIXEL_BITS{1'b0}};
    end else begin
      fb_rd_en_q  <= fb_rd_en_d;
      fb_addr_q   <= fb_addr_d;
      addr_cnt_q  <= addr_cnt_d;
      meta_q      <= meta_d;
      pix_valid_q <= pix_valid_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      visible_q   <= visible_d;
      rgb_q       <= rgb_d;
    end
  end

  assign fb.fb_rd_en = fb_rd_en_q;
  assign fb.fb_addr  = fb_addr_q;
  assign pix_valid   = pix_valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_fb_pixel_stream.sv
// Bench for vga_fb_pixel_stream: four instances (read latency 2, 1 and 3 at VGA geometry, plus a
// small geometry) run from one stimulus stream against a cycle-indexed expectation model.
module tb_vga_fb_pixel_stream;

  localparam int NI = 4;
  localparam int HV_A  [NI] = '{640, 640, 640, 8};
  localparam int HFP_A [NI] = '{16, 16, 16, 2};
  localparam int HSP_A [NI] = '{96, 96, 96, 3};
  localparam int VV_A  [NI] = '{480, 480, 480, 6};
  localparam int VFP_A [NI] = '{10, 10, 10, 1};
  localparam int VSP_A [NI] = '{2, 2, 2, 2};
  localparam int RL_A  [NI] = '{2, 1, 3, 2};
  localparam int CM_A  [NI] = '{1023, 1023, 1023, 15};
  localparam int RM_A  [NI] = '{1023, 1023, 1023, 15};

  logic       clk = 1'b0;
  logic       reset_s;
  logic       enable_s;
  logic [9:0] column_s;
  logic [9:0] row_s;

  logic        rd_en_o [NI];
  logic [18:0] addr_o  [NI];
  logic        pv_o    [NI];
  logic        hs_o    [NI];
  logic        vs_o    [NI];
  logic        vis_o   [NI];
  logic [11:0] rgb_o   [NI];

  always #5 clk = ~clk;

  // Framebuffer contents as a fixed function of the address; address 0 holds 0xABC.
  function automatic logic [11:0] mem_f(input logic [18:0] a);
    logic [18:0] t;
    t = a * 19'd29;
    return 12'hABC ^ t[11:0] ^ {5'd0, t[18:12]};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RL  = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
    localparam bit SM  = (g == 3);
    localparam int HWL = SM ? 16 : 800;
    localparam int VWF = SM ? 12 : 525;
    localparam int CB  = $clog2(HWL);
    localparam int RB  = $clog2(VWF);

    vga_fb_pixel_stream_if #(.ADDR_BITS(19), .PIXEL_BITS(12)) fb_if ();
    logic [11:0] dpipe [RL];

    vga_fb_pixel_stream #(
      .H_VISIBLE(SM ? 8 : 640), .H_FRONT_PORCH(SM ? 2 : 16), .H_SYNC_PULSE(SM ? 3 : 96),
      .H_WHOLE_LINE(HWL), .V_VISIBLE(SM ? 6 : 480), .V_FRONT_PORCH(SM ? 1 : 10),
      .V_SYNC_PULSE(2), .V_WHOLE_FRAME(VWF), .READ_LATENCY(RL),
      .PIXEL_BITS(12), .ADDR_BITS(19)
    ) u_dut (
      .clk(clk), .reset(reset_s), .enable(enable_s),
      .column(column_s[CB-1:0]), .row(row_s[RB-1:0]), .fb(fb_if),
      .pix_valid(pv_o[g]), .hsync(hs_o[g]), .vsync(vs_o[g]),
      .visible(vis_o[g]), .rgb(rgb_o[g])
    );

    // Memory model: data for a read appears RL cycles after the strobe; otherwise noise.
    always @(posedge clk) begin
      dpipe[0] <= fb_if.fb_rd_en ? mem_f(fb_if.fb_addr) : 12'($urandom);
      for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
    end

    assign fb_if.fb_data = dpipe[RL-1];
    assign rd_en_o[g]    = fb_if.fb_rd_en;
    assign addr_o[g]     = fb_if.fb_addr;
  end

  typedef struct packed {
    logic        v;
    logic        vis;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } ent_t;

  ent_t        sched [NI][8];
  logic        e_pv  [NI];
  logic        e_hs  [NI];
  logic        e_vs  [NI];
  logic        e_vis [NI];
  logic        e_rd  [NI];
  logic [11:0] e_rgb [NI];
  logic [18:0] e_addr[NI];
  logic [18:0] cnt   [NI];
  logic [NI-1:0] lin_mask;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, g, cyc, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the expectation model, then check every instance.
  task automatic step(input bit en, input int c, input int r, input bit rst);
    int cc, rr, lin[NI];
    bit vis, hs, vs, lin_v[NI];
    enable_s = en;
    column_s = 10'(c);
    row_s    = 10'(r);
    reset_s  = rst;
    for (int g = 0; g < NI; g++) begin
      lin_v[g] = 1'b0;
      lin[g]   = 0;
      cc = c & CM_A[g];
      rr = r & RM_A[g];
      if (!rst) begin
        for (int s = 0; s < 8; s++) sched[g][s].v = 1'b0;
        e_pv[g] = 1'b0; e_hs[g] = 1'b1; e_vs[g] = 1'b1; e_vis[g] = 1'b0;
        e_rgb[g] = 12'h000; e_rd[g] = 1'b0; e_addr[g] = 19'd0; cnt[g] = 19'd0;
      end else begin
        if (sched[g][(cyc + 1) % 8].v) begin
          e_pv[g]  = 1'b1;
          e_hs[g]  = sched[g][(cyc + 1) % 8].hs;
          e_vs[g]  = sched[g][(cyc + 1) % 8].vs;
          e_vis[g] = sched[g][(cyc + 1) % 8].vis;
          e_rgb[g] = sched[g][(cyc + 1) % 8].rgb;
          sched[g][(cyc + 1) % 8].v = 1'b0;
        end else begin
          e_pv[g] = 1'b0;
        end
        e_rd[g] = 1'b0;
        if (en) begin
          vis = (cc < HV_A[g]) && (rr < VV_A[g]);
          hs  = !((cc >= HV_A[g] + HFP_A[g]) && (cc < HV_A[g] + HFP_A[g] + HSP_A[g]));
          vs  = !((rr >= VV_A[g] + VFP_A[g]) && (rr < VV_A[g] + VFP_A[g] + VSP_A[g]));
          if (cc == 0 && rr == 0) begin
            e_addr[g] = 19'd0;
            cnt[g]    = 19'd1;
          end else if (vis) begin
            e_addr[g] = cnt[g];
            cnt[g]    = cnt[g] + 19'd1;
          end
          e_rd[g] = vis;
          sched[g][(cyc + 2 + RL_A[g]) % 8] = '{v: 1'b1, vis: vis, hs: hs, vs: vs,
                                               rgb: (vis ? mem_f(e_addr[g]) : 12'h000)};
          if (lin_mask[g] && vis) begin
            lin_v[g] = 1'b1;
            lin[g]   = rr * HV_A[g] + cc;
          end
        end
      end
    end
    @(negedge clk);
    cyc++;
    for (int g = 0; g < NI; g++) begin
      chk("rd_en", g, 32'(rd_en_o[g]), 32'(e_rd[g]));
      chk("addr", g, 32'(addr_o[g]), 32'(e_addr[g]));
      chk("pix_valid", g, 32'(pv_o[g]), 32'(e_pv[g]));
      chk("hsync", g, 32'(hs_o[g]), 32'(e_hs[g]));
      chk("vsync", g, 32'(vs_o[g]), 32'(e_vs[g]));
      chk("visible", g, 32'(vis_o[g]), 32'(e_vis[g]));
      chk("rgb", g, 32'(rgb_o[g]), 32'(e_rgb[g]));
      if (lin_v[g]) chk("lin_addr", g, 32'(addr_o[g]), 32'(lin[g]));
    end
  endtask

  initial begin
    lin_mask = 4'b0000;
    repeat (3) step(1'b0, 0, 0, 1'b0);

    // Rows 0 and 1 rastered from (0,0): linear addresses, hsync window, blanking.
    lin_mask = 4'b0111;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 800; c++) step(1'b1, c, r, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b1, c, 2, 1'b1);

    // Jump into the vertical blanking band around the vsync pulse.
    lin_mask = 4'b0000;
    for (int r = 486; r < 495; r++)
      for (int i = 0; i < 8; i++) step(1'b1, int'($urandom_range(0, 799)), r, 1'b1);

    // Alternating enable; disabled cycles carry random coordinates that must be ignored.
    lin_mask = 4'b0111;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) step(1'b1, i / 2, 0, 1'b1);
      else step(1'b0, int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'b1);
    end

    // Reset mid-line at column 300 together with enable, then recovery at the next frame start.
    for (int c = 0; c < 300; c++) step(1'b1, c, 0, 1'b1);
    lin_mask = 4'b0000;
    step(1'b1, 300, 0, 1'b0);
    for (int c = 301; c < 800; c++) step(1'b1, c, 0, 1'b1);
    lin_mask = 4'b0111;
    for (int c = 0; c < 800; c++) step(1'b1, c, 0, 1'b1);
    step(1'b1, 0, 1, 1'b1);

    // Two whole frames of the small geometry: last read at 47, then back to 0.
    lin_mask = 4'b1000;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 16; c++) step(1'b1, c, r, 1'b1);
    step(1'b1, 0, 0, 1'b1);

    // Random coordinates, enable gaps, occasional frame starts and resets.
    lin_mask = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 0, 0, 1'b1);
      else
        step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 799)),
             int'($urandom_range(0, 524)), ($urandom_range(0, 199) != 0));
    end
    repeat (8) step(1'b0, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_pixel_stream.md
Name: vga_fb_pixel_stream

Overview:
- Downstream stage of the VGA pixel address counter. Consumes its column/row stream and produces the display-side pixel stream.
- Decodes the sync and visible regions for each pixel.
- Issues one framebuffer read per visible pixel using a linear address counter; no multiplier.
- Delays sync/visible through a fixed pipeline so they leave aligned with the returned pixel data. Feeds the DAC/output register stage.

Parameters:
- H_VISIBLE, 640, visible columns
- H_FRONT_PORCH, 16, columns between visible end and hsync start
- H_SYNC_PULSE, 96, hsync width in columns
- H_WHOLE_LINE, 800, columns per line (sets COLUMN_BITS = clog2)
- V_VISIBLE, 480, visible rows
- V_FRONT_PORCH, 10, rows between visible end and vsync start
- V_SYNC_PULSE, 2, vsync width in rows
- V_WHOLE_FRAME, 525, rows per frame (sets ROW_BITS = clog2)
- READ_LATENCY, 2, clk cycles from fb_rd_en to valid fb_data (fixed, ≥1)
- PIXEL_BITS, 12, framebuffer word / rgb width
- ADDR_BITS, 19, framebuffer address width (must hold H_VISIBLE*V_VISIBLE-1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- enable  in  1  pixel strobe; column/row sampled only when high
- column  in  COLUMN_BITS  current column from pixel address counter
- row  in  ROW_BITS  current row from pixel address counter
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  ADDR_BITS  framebuffer read address
- fb_data  in  PIXEL_BITS  read data, valid READ_LATENCY cycles after fb_rd_en
- pix_valid  out  1  one-cycle strobe per sampled pixel
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- visible  out  1  pixel is in active area
- rgb  out  PIXEL_BITS  pixel colour, 0 outside active area

Behaviour:
- Reset (reset==0, synchronous) clears all pipeline valid bits and the address counter.
- Outputs on reset: fb_rd_en=0, fb_addr=0, pix_valid=0, hsync=1, vsync=1, visible=0, rgb=0.
- Stage 0 decode, per enable cycle at cycle t:
  - vis = column<H_VISIBLE && row<V_VISIBLE
  - hs_n = 0 iff H_VISIBLE+H_FRONT_PORCH ≤ column < H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE
  - vs_n = 0 iff V_VISIBLE+V_FRONT_PORCH ≤ row < V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE
- Stage 1 (cycle t+1), registered:
  - fb_rd_en = enable_t && vis.
  - fb_addr = address counter value. Counter is forced to 0 when the sampled pixel is (0,0), otherwise increments by 1 after each visible sample.
  - Result: visible pixel (c,r) reads address r*H_VISIBLE+c. Non-visible samples leave the counter unchanged.
- fb_addr holds its last value when fb_rd_en=0.
- Delay line: {valid, vis, hs_n, vs_n} shifts every clk (not gated by enable). Length is such that outputs update at cycle t+2+READ_LATENCY (L=4 at default).
- On an output update: pix_valid=1, hsync/vsync/visible from the delay line, rgb = vis ? fb_data : 0. fb_data is registered in the same cycle it is valid.
- Cycles carrying a bubble (enable was low): pix_valid=0; hsync, vsync, visible and rgb hold their previous values.
- Enable low never stalls in-flight reads; the data pipeline advances every clk.
- No addr wrap logic beyond the frame-start clear. If column/row jump mid-frame, the addresses are wrong until the next (0,0) sample; no error output.
- Reset mid-operation discards all in-flight entries. fb_data returning after reset is ignored. The first output after reset is pix_valid at cycle L after the first enabled sample.
- Simultaneous enable and reset: reset wins and the sample is dropped.

Test Plan:
- enable held 1, counter starting at (0,0) → fb_rd_en=1, fb_addr=0 at cycle 1; with model fb_data=0xABC returned at cycle 3 → pix_valid=1, visible=1, rgb=0xABC, hsync=1, vsync=1 at cycle 4.
- Row 0 sweep → fb_addr 0..639 on consecutive cycles. Columns 640..799 give fb_rd_en=0 and rgb=0. hsync=0 exactly for columns 656..751 (96 pixels), delayed by 4. Row 1 col 0 → fb_addr=640.
- Full frame → last read (639,479) at fb_addr=307199. Rows 480..524 issue no reads. vsync=0 only for rows 490..491. Next (0,0) → fb_addr=0.
- enable toggled 1,0,1,0 → pix_valid alternates with 4-cycle lag. Each rgb matches the data returned for its own address. Outputs hold during bubbles.
- reset=0 for 1 cycle mid-line at column 300 → next cycle all outputs at reset values. In-flight data dropped (no pix_valid for 4 cycles after the first new enabled sample). Addresses resume correctly after the next (0,0).
- READ_LATENCY=1 and =3 builds → output latency 3 and 5 respectively; alignment checks as in scenario 1.
